// File: rtl/shift_pkg.sv
// Shared constants for the execute-stage shift datapath.
// Op encodings and default width used by the shifter and its arbiter.
package shift_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int SHW       = $clog2(DEF_WIDTH);

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;
endpackage

// File: rtl/shift_core.sv
// Combinational SLL/SRA barrel shifter, one stage per shift-amount bit.
// Zero latency; no handshake, the arbiter owns all flow control.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int SW   = $clog2(WIDTH)
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shamt,
  input  logic             op
);

  logic [SW:0][WIDTH-1:0] stage;
  logic                   fill;

  // Arithmetic shifts never alter the sign bit, so every stage can fill from the original MSB.
  assign fill     = (op == OP_SRA) & data[WIDTH-1];
  assign stage[0] = data;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    localparam int S = 1 << i;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    assign shl          = {stage[i][WIDTH-S-1:0], {S{1'b0}}};
    assign shr          = {{S{fill}}, stage[i][WIDTH-1:S]};
    assign stage[i+1]   = shamt[i] ? ((op == OP_SRA) ? shr : shl) : stage[i];
  end

  assign out = stage[SW];

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin share of one shifter between ALU (port 0) and multdiv (port 1).
// Accept-to-response 1 cycle; a held result blocks both request ports until drained.
module shifter_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAGW  = 4,
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic             req_op0,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [SW-1:0]    req_shamt0,
  input  logic [TAGW-1:0]  req_tag0,

  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic             req_op1,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [SW-1:0]    req_shamt1,
  input  logic [TAGW-1:0]  req_tag1,

  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAGW-1:0]  rsp_tag
);

  logic             slot_full;
  logic             slot_owner;
  logic             rr_ptr;
  logic             drain;
  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [SW-1:0]    sel_shamt;
  logic [TAGW-1:0]  sel_tag;
  logic [WIDTH-1:0] shifted;

  assign drain      = slot_full & (slot_owner ? rsp_ready1 : rsp_ready0);
  assign can_accept = ~slot_full | drain;

  // rr_ptr names the port that wins a tie: the one not granted last time.
  assign grant1 = req_valid1 & (~req_valid0 | rr_ptr);
  assign grant0 = req_valid0 & ~grant1;

  assign req_ready0 = ~reset & can_accept & grant0;
  assign req_ready1 = ~reset & can_accept & grant1;
  assign accept     = req_ready0 | req_ready1;

  assign sel_op    = grant1 ? req_op1    : req_op0;
  assign sel_data  = grant1 ? req_data1  : req_data0;
  assign sel_shamt = grant1 ? req_shamt1 : req_shamt0;
  assign sel_tag   = grant1 ? req_tag1   : req_tag0;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .out   (shifted),
    .data  (sel_data),
    .shamt (sel_shamt),
    .op    (sel_op)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_full  <= 1'b0;
      slot_owner <= 1'b0;
      rr_ptr     <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
    end else if (accept) begin
      rsp_data   <= shifted;
      rsp_tag    <= sel_tag;
      slot_owner <= grant1;
      slot_full  <= 1'b1;
      rr_ptr     <= ~grant1;
    end else if (drain) begin
      slot_full  <= 1'b0;
    end
  end

  assign rsp_valid0 = slot_full & ~slot_owner;
  assign rsp_valid1 = slot_full &  slot_owner;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed and randomized checks of the shared shifter arbiter.
module tb_shifter_arbiter;
  import shift_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid0, req_ready0, req_op0;
  logic [31:0] req_data0;
  logic [4:0]  req_shamt0;
  logic [3:0]  req_tag0;
  logic        req_valid1, req_ready1, req_op1;
  logic [31:0] req_data1;
  logic [4:0]  req_shamt1;
  logic [3:0]  req_tag1;
  logic        rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clock = ~clock;

  shifter_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid0(req_valid0), .req_ready0(req_ready0), .req_op0(req_op0),
    .req_data0(req_data0), .req_shamt0(req_shamt0), .req_tag0(req_tag0),
    .req_valid1(req_valid1), .req_ready1(req_ready1), .req_op1(req_op1),
    .req_data1(req_data1), .req_shamt1(req_shamt1), .req_tag1(req_tag1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag)
  );

  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] d, input logic [4:0] sh);
    logic signed [31:0] sd;
    sd = d;
    if (op) return sd >>> sh;
    return d << sh;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid0 = 0; req_op0 = 0; req_data0 = 0; req_shamt0 = 0; req_tag0 = 0;
    req_valid1 = 0; req_op1 = 0; req_data1 = 0; req_shamt1 = 0; req_tag1 = 0;
    rsp_ready0 = 0; rsp_ready1 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    req_valid0 = 1;
    req_valid1 = 1;
    tick();
    tick();
    #1;
    total++; if (rsp_valid0 !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid0 got=%b exp=0", rsp_valid0); end
    total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid1 got=%b exp=0", rsp_valid1); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    total++; if (rsp_tag !== 4'h0) begin bad++; $display("FAIL reset_rsp_tag got=%h exp=0", rsp_tag); end
    total++; if ({req_ready0, req_ready1} !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", {req_ready0, req_ready1}); end
    req_valid0 = 0;
    req_valid1 = 0;
    reset = 0;
    tick();
  endtask

  task automatic test_port0();
    req_valid0 = 1; req_op0 = OP_SLL; req_data0 = 32'h0000_0001; req_shamt0 = 5'd31; req_tag0 = 4'h5;
    #1;
    total++; if ({req_ready0, req_ready1} !== 2'b10) begin bad++; $display("FAIL p0_req_ready got=%b exp=10", {req_ready0, req_ready1}); end
    tick();
    req_valid0 = 0;
    rsp_ready0 = 1;
    #1;
    total++; if ({rsp_valid0, rsp_valid1} !== 2'b10) begin bad++; $display("FAIL p0_rsp_valid got=%b exp=10", {rsp_valid0, rsp_valid1}); end
    total++; if (rsp_data !== 32'h8000_0000) begin bad++; $display("FAIL p0_rsp_data got=%h exp=80000000", rsp_data); end
    total++; if (rsp_tag !== 4'h5) begin bad++; $display("FAIL p0_rsp_tag got=%h exp=5", rsp_tag); end
    tick();
    rsp_ready0 = 0;
    #1;
    total++; if (rsp_valid0 !== 1'b0) begin bad++; $display("FAIL p0_drained got=%b exp=0", rsp_valid0); end
    tick();
  endtask

  task automatic test_port1();
    logic        vop [5]  = '{OP_SRA, OP_SRA, OP_SLL, OP_SRA, OP_SLL};
    logic [31:0] vdat [5] = '{32'h8000_0000, 32'h7FFF_FFF0, 32'hDEAD_BEEF, 32'h8000_0000, 32'h1234_5678};
    logic [4:0]  vsh [5]  = '{5'd4, 5'd4, 5'd0, 5'd31, 5'd8};
    logic [31:0] vexp [5] = '{32'hF800_0000, 32'h07FF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h3456_7800};
    for (int k = 0; k < 5; k++) begin
      req_valid1 = 1; req_op1 = vop[k]; req_data1 = vdat[k]; req_shamt1 = vsh[k]; req_tag1 = 4'(k + 2);
      #1;
      total++; if ({req_ready0, req_ready1} !== 2'b01) begin bad++; $display("FAIL p1_req_ready[%0d] got=%b exp=01", k, {req_ready0, req_ready1}); end
      tick();
      req_valid1 = 0;
      rsp_ready1 = 1;
      #1;
      total++; if (rsp_valid1 !== 1'b1 || rsp_data !== vexp[k] || rsp_tag !== 4'(k + 2))
        begin bad++; $display("FAIL p1_rsp[%0d] got v=%b d=%h t=%h exp v=1 d=%h t=%h", k, rsp_valid1, rsp_data, rsp_tag, vexp[k], 4'(k + 2)); end
      tick();
      rsp_ready1 = 0;
    end
    tick();
  endtask

  task automatic test_alternate();
    logic        w;
    int          idx;
    logic [31:0] ed;
    logic [3:0]  et;
    reset = 1;
    tick();
    reset = 0;
    rsp_ready0 = 1;
    rsp_ready1 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      req_valid0 = 1; req_op0 = OP_SLL; req_shamt0 = 5'd1;
      req_data0 = 32'((i + 1) / 2 + 1); req_tag0 = 4'((i + 1) / 2);
      req_valid1 = 1; req_op1 = OP_SLL; req_shamt1 = 5'd1;
      req_data1 = 32'h100 + 32'(i / 2); req_tag1 = 4'(8 + i / 2);
      #1;
      total++; if ({req_ready0, req_ready1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        begin bad++; $display("FAIL alt_grant[%0d] got=%b exp=%b", i, {req_ready0, req_ready1}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      if (i > 0) begin
        w = ((i - 1) % 2 == 1);
        if (!w) begin idx = i / 2;       ed = 32'(idx + 1) << 1;       et = 4'(idx); end
        else    begin idx = (i - 1) / 2; ed = (32'h100 + 32'(idx)) << 1; et = 4'(8 + idx); end
        total++; if ({rsp_valid0, rsp_valid1} !== {~w, w} || rsp_data !== ed || rsp_tag !== et)
          begin bad++; $display("FAIL alt_rsp[%0d] got v=%b%b d=%h t=%h exp v=%b%b d=%h t=%h", i, rsp_valid0, rsp_valid1, rsp_data, rsp_tag, ~w, w, ed, et); end
      end
    end
    tick();
    req_valid0 = 0;
    req_valid1 = 0;
    #1;
    total++; if (rsp_valid1 !== 1'b1 || rsp_data !== 32'h0000_0204 || rsp_tag !== 4'hA)
      begin bad++; $display("FAIL alt_last got v=%b d=%h t=%h exp v=1 d=00000204 t=a", rsp_valid1, rsp_data, rsp_tag); end
    tick();
    rsp_ready0 = 0;
    rsp_ready1 = 0;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready0 = 0;
    rsp_ready1 = 1;
    req_valid0 = 1; req_op0 = OP_SLL; req_data0 = 32'h0000_F00F; req_shamt0 = 5'd4; req_tag0 = 4'h3;
    #1;
    total++; if (req_ready0 !== 1'b1) begin bad++; $display("FAIL bp_first_accept got=%b exp=1", req_ready0); end
    tick();
    req_valid0 = 0;
    req_valid1 = 1; req_op1 = OP_SRA; req_data1 = 32'h8000_0010; req_shamt1 = 5'd1; req_tag1 = 4'h9;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_ready1 !== 1'b0 || rsp_valid0 !== 1'b1 || rsp_data !== 32'h000F_00F0 || rsp_tag !== 4'h3)
        begin bad++; $display("FAIL bp_hold[%0d] got rdy1=%b v0=%b d=%h t=%h exp rdy1=0 v0=1 d=000f00f0 t=3", c, req_ready1, rsp_valid0, rsp_data, rsp_tag); end
      tick();
    end
    rsp_ready0 = 1;
    #1;
    total++; if (req_ready1 !== 1'b1) begin bad++; $display("FAIL bp_drain_accept got=%b exp=1", req_ready1); end
    tick();
    rsp_ready0 = 0;
    req_valid1 = 0;
    #1;
    total++; if ({rsp_valid0, rsp_valid1} !== 2'b01 || rsp_data !== 32'hC000_0008 || rsp_tag !== 4'h9)
      begin bad++; $display("FAIL bp_p1_rsp got v=%b%b d=%h t=%h exp v=01 d=c0000008 t=9", rsp_valid0, rsp_valid1, rsp_data, rsp_tag); end
    tick();
    #1;
    total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", rsp_valid1); end
    rsp_ready1 = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready0 = 0;
    rsp_ready1 = 0;
    req_valid0 = 1; req_op0 = OP_SLL; req_data0 = 32'h0000_000A; req_shamt0 = 5'd0; req_tag0 = 4'h1;
    tick();
    req_valid1 = 1; req_op1 = OP_SRA; req_data1 = 32'h1; req_shamt1 = 5'd0; req_tag1 = 4'h2;
    req_tag0 = 4'h4;
    #1;
    total++; if ({req_ready0, req_ready1, rsp_valid0} !== 3'b001)
      begin bad++; $display("FAIL rm_full got rdy=%b%b v0=%b exp rdy=00 v0=1", req_ready0, req_ready1, rsp_valid0); end
    reset = 1;
    tick();
    #1;
    total++; if ({rsp_valid0, rsp_valid1, req_ready0, req_ready1} !== 4'b0000)
      begin bad++; $display("FAIL rm_in_reset got v=%b%b rdy=%b%b exp all 0", rsp_valid0, rsp_valid1, req_ready0, req_ready1); end
    reset = 0;
    #1;
    total++; if ({req_ready0, req_ready1} !== 2'b10) begin bad++; $display("FAIL rm_first_tie got=%b exp=10", {req_ready0, req_ready1}); end
    tick();
    req_valid0 = 0;
    req_valid1 = 0;
    rsp_ready0 = 1;
    #1;
    total++; if (rsp_valid0 !== 1'b1 || rsp_tag !== 4'h4 || rsp_data !== 32'h0000_000A)
      begin bad++; $display("FAIL rm_after got v0=%b t=%h d=%h exp v0=1 t=4 d=0000000a", rsp_valid0, rsp_tag, rsp_data); end
    tick();
  endtask

  task automatic test_random();
    int   accepted = 0;
    int   cycles   = 0;
    bit   pend0 = 0;
    bit   pend1 = 0;
    exp_t e;
    q0.delete();
    q1.delete();
    while (accepted < 10000 && cycles < 60000) begin
      tick();
      cycles++;
      if (!pend0) begin
        req_valid0 = ($urandom_range(0, 3) != 0); req_op0 = 1'($urandom_range(0, 1));
        req_data0 = $urandom; req_shamt0 = 5'($urandom_range(0, 31)); req_tag0 = 4'($urandom_range(0, 15));
        pend0 = req_valid0;
      end
      if (!pend1) begin
        req_valid1 = ($urandom_range(0, 3) != 0); req_op1 = 1'($urandom_range(0, 1));
        req_data1 = $urandom; req_shamt1 = 5'($urandom_range(0, 31)); req_tag1 = 4'($urandom_range(0, 15));
        pend1 = req_valid1;
      end
      rsp_ready0 = ($urandom_range(0, 3) != 0);
      rsp_ready1 = ($urandom_range(0, 3) != 0);
      #1;
      total++; if ((req_ready0 & req_ready1) | (req_ready0 & ~req_valid0) | (req_ready1 & ~req_valid1) | (rsp_valid0 & rsp_valid1))
        begin bad++; $display("FAIL rnd_invariant cyc=%0d got rdy=%b%b vld=%b%b rsp=%b%b", cycles, req_ready0, req_ready1, req_valid0, req_valid1, rsp_valid0, rsp_valid1); end
      if (rsp_valid0 && rsp_ready0) begin
        total++;
        if (q0.size() == 0) begin bad++; $display("FAIL rnd_p0_extra cyc=%0d got d=%h t=%h exp none", cycles, rsp_data, rsp_tag); end
        else begin
          e = q0.pop_front();
          if (rsp_data !== e.d || rsp_tag !== e.t) begin bad++; $display("FAIL rnd_p0 cyc=%0d got d=%h t=%h exp d=%h t=%h", cycles, rsp_data, rsp_tag, e.d, e.t); end
        end
      end
      if (rsp_valid1 && rsp_ready1) begin
        total++;
        if (q1.size() == 0) begin bad++; $display("FAIL rnd_p1_extra cyc=%0d got d=%h t=%h exp none", cycles, rsp_data, rsp_tag); end
        else begin
          e = q1.pop_front();
          if (rsp_data !== e.d || rsp_tag !== e.t) begin bad++; $display("FAIL rnd_p1 cyc=%0d got d=%h t=%h exp d=%h t=%h", cycles, rsp_data, rsp_tag, e.d, e.t); end
        end
      end
      if (req_valid0 && req_ready0) begin
        e.d = ref_shift(req_op0, req_data0, req_shamt0); e.t = req_tag0;
        q0.push_back(e); pend0 = 0; accepted++;
      end
      if (req_valid1 && req_ready1) begin
        e.d = ref_shift(req_op1, req_data1, req_shamt1); e.t = req_tag1;
        q1.push_back(e); pend1 = 0; accepted++;
      end
    end
    total++; if (accepted < 10000) begin bad++; $display("FAIL rnd_timeout got=%0d exp=10000 accepts", accepted); end
    for (int c = 0; c < 4; c++) begin
      tick();
      req_valid0 = 0; req_valid1 = 0;
      rsp_ready0 = 1; rsp_ready1 = 1;
      #1;
      if (rsp_valid0) begin
        total++;
        if (q0.size() == 0) begin bad++; $display("FAIL rnd_p0_extra_tail got d=%h exp none", rsp_data); end
        else begin e = q0.pop_front(); if (rsp_data !== e.d || rsp_tag !== e.t) begin bad++; $display("FAIL rnd_p0_tail got d=%h t=%h exp d=%h t=%h", rsp_data, rsp_tag, e.d, e.t); end end
      end
      if (rsp_valid1) begin
        total++;
        if (q1.size() == 0) begin bad++; $display("FAIL rnd_p1_extra_tail got d=%h exp none", rsp_data); end
        else begin e = q1.pop_front(); if (rsp_data !== e.d || rsp_tag !== e.t) begin bad++; $display("FAIL rnd_p1_tail got d=%h t=%h exp d=%h t=%h", rsp_data, rsp_tag, e.d, e.t); end end
      end
    end
    total++; if (q0.size() != 0 || q1.size() != 0) begin bad++; $display("FAIL rnd_lost got q0=%0d q1=%0d exp 0 0", q0.size(), q1.size()); end
  endtask

  initial begin
    test_reset();
    test_port0();
    test_port1();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
